// File: rtl/score_pkg.sv
// Shared constants, clear-FSM state type and stat-counting helper for score_tracker.
package score_pkg;

  localparam int DEF_HIGH_TH   = 6;
  localparam int DEF_LOW_TH    = 2;
  localparam int DEF_BONUS_PTS = 5;
  localparam int DEF_DEAD_PEN  = 5;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    COUNT = 2'd1,
    FIRED = 2'd2
  } clr_state_e;

  // Number of the first n fields (each w bits wide) of vec that are >= th.
  function automatic int unsigned popcount_ge(input logic [63:0] vec, input int unsigned n,
                                              input int unsigned w, input int unsigned th);
    int unsigned cnt;
    logic [63:0] field;
    cnt = 0;
    for (int unsigned i = 0; i < n; i++) begin
      field = (vec >> (i * w)) & ((64'd1 << w) - 64'd1);
      if (field >= 64'(th)) cnt++;
    end
    return cnt;
  endfunction

endpackage

// File: rtl/score_bin2bcd.sv
// Iterative double-dabble binary-to-BCD converter with start/busy/done handshake.
module score_bin2bcd #(
  parameter int BIN_W  = 14,
  parameter int DIGITS = 4
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  start_i,
  input  logic [BIN_W-1:0]      bin_i,
  output logic                  busy_o,
  output logic                  done_o,
  output logic [4*DIGITS-1:0]   bcd_o
);

  localparam int CW = $clog2(BIN_W + 1);

  logic [BIN_W-1:0]    bin_q;
  logic [4*DIGITS-1:0] acc_q, acc_adj, bcd_q;
  logic [CW-1:0]       cnt_q;
  logic                busy_q, done_q;

  always_comb begin
    acc_adj = acc_q;
    for (int d = 0; d < DIGITS; d++) begin
      if (acc_q[4*d +: 4] >= 4'd5) acc_adj[4*d +: 4] = acc_q[4*d +: 4] + 4'd3;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      bin_q  <= '0;
      acc_q  <= '0;
      bcd_q  <= '0;
      cnt_q  <= '0;
      busy_q <= 1'b0;
      done_q <= 1'b0;
    end else if (start_i) begin
      bin_q  <= bin_i;
      acc_q  <= '0;
      cnt_q  <= CW'(BIN_W);
      busy_q <= 1'b1;
      done_q <= 1'b0;
    end else if (busy_q) begin
      if (cnt_q != '0) begin
        acc_q <= {acc_adj[4*DIGITS-2:0], bin_q[BIN_W-1]};
        bin_q <= bin_q << 1;
        cnt_q <= cnt_q - CW'(1);
      end else begin
        busy_q <= 1'b0;
        done_q <= 1'b1;
        bcd_q  <= acc_q;
      end
    end else begin
      done_q <= 1'b0;
    end
  end

  assign busy_o = busy_q;
  assign done_o = done_q;
  assign bcd_o  = bcd_q;

endmodule

// File: rtl/score_tracker.sv
// Saturating pet-game score with decay tick, best score and long-press clear.
// Optional BCD output of the score when SCORE_BCD_EN is defined.
module score_tracker
  import score_pkg::*;
#(
  parameter int N_STATS     = 5,
  parameter int STAT_W      = 3,
  parameter int SCORE_W     = 14,
  parameter int SCORE_MAX   = 9999,
  parameter int HIGH_TH     = DEF_HIGH_TH,
  parameter int LOW_TH      = DEF_LOW_TH,
  parameter int BONUS_PTS   = DEF_BONUS_PTS,
  parameter int DEAD_PEN    = DEF_DEAD_PEN,
  parameter int DEAD_MIN    = 2,
  parameter int TICK_CYCLES = 50000000,
  parameter int HOLD_CYCLES = 250000000
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic [N_STATS*STAT_W-1:0]  stats,
  input  logic                       pause,
  input  logic                       clear_btn,
  output logic [SCORE_W-1:0]         score,
  output logic [SCORE_W-1:0]         best_score,
  output logic                       tick,
  output logic                       cleared,
  output logic                       new_best
`ifdef SCORE_BCD_EN
  , output logic [15:0]              score_bcd
  , output logic                     bcd_valid
`endif
);

  localparam int GW  = $clog2(N_STATS + BONUS_PTS + 1);
  localparam int LW  = $clog2(N_STATS + DEAD_PEN + 1);
  localparam int TW  = $clog2(TICK_CYCLES + 1);
  localparam int HW  = $clog2(HOLD_CYCLES + 1);
  localparam int SW2 = SCORE_W + 2;
  localparam logic [STAT_W-1:0] STAT_MAX = '1;

  clr_state_e state_q, state_d;
  logic [HW-1:0]      hold_q, hold_d;
  logic [TW-1:0]      tcnt_q, tcnt_d;
  logic [N_STATS-1:0] healthy_q, healthy_now;
  logic               bonus_q, all_max;
  logic [SCORE_W-1:0] score_q, score_d, best_q;
  logic               tick_q, cleared_q, new_best_q;
  logic               fire, hold_done, tick_now;
  logic [GW-1:0]      gain;
  logic [LW-1:0]      loss;
  int unsigned        weak_cnt, dead_cnt;
  logic signed [SW2-1:0] sum;

  always_comb begin
    for (int i = 0; i < N_STATS; i++) begin
      healthy_now[i] = stats[i*STAT_W +: STAT_W] >= STAT_W'(HIGH_TH);
    end
  end

  assign all_max   = (stats == {N_STATS{STAT_MAX}});
  assign hold_done = (hold_q >= HW'(HOLD_CYCLES - 1));
  assign tick_now  = !pause && !fire && (tcnt_q == TW'(TICK_CYCLES - 1));

  // Clear FSM: state register, next state, outputs
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      hold_q  <= '0;
    end else begin
      state_q <= state_d;
      hold_q  <= hold_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (clear_btn) state_d = COUNT;
      COUNT:   if (!clear_btn) state_d = IDLE;
               else if (hold_done) state_d = FIRED;
      FIRED:   if (!clear_btn) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    fire   = 1'b0;
    hold_d = '0;
    case (state_q)
      IDLE:    if (clear_btn) hold_d = HW'(1);
      COUNT:   if (clear_btn) begin
                 if (hold_done) fire = 1'b1;
                 else hold_d = hold_q + HW'(1);
               end
      default: hold_d = '0;
    endcase
  end

  always_comb begin
    if (fire)                                   tcnt_d = '0;
    else if (pause)                             tcnt_d = tcnt_q;
    else if (tcnt_q == TW'(TICK_CYCLES - 1))    tcnt_d = '0;
    else                                        tcnt_d = tcnt_q + TW'(1);
  end

  always_comb begin
    weak_cnt = N_STATS - popcount_ge(64'(stats), N_STATS, STAT_W, LOW_TH + 1);
    dead_cnt = N_STATS - popcount_ge(64'(stats), N_STATS, STAT_W, 1);
    gain = '0;
    if (!pause) begin
      gain = GW'($countones(healthy_now & ~healthy_q));
      if (all_max && !bonus_q) gain = gain + GW'(BONUS_PTS);
    end
    loss = '0;
    if (tick_now) begin
      loss = LW'(weak_cnt);
      if (dead_cnt >= DEAD_MIN) loss = loss + LW'(DEAD_PEN);
    end
  end

  // Gain and loss are merged in one signed sum so neither can mask the other.
  always_comb begin
    sum = $signed({2'b00, score_q}) + $signed(SW2'(gain)) - $signed(SW2'(loss));
    if (fire)                                  score_d = '0;
    else if (sum < 0)                          score_d = '0;
    else if (sum > $signed(SW2'(SCORE_MAX)))   score_d = SCORE_W'(SCORE_MAX);
    else                                       score_d = sum[SCORE_W-1:0];
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      healthy_q  <= '1;
      bonus_q    <= 1'b1;
      score_q    <= '0;
      best_q     <= '0;
      tcnt_q     <= '0;
      tick_q     <= 1'b0;
      cleared_q  <= 1'b0;
      new_best_q <= 1'b0;
    end else begin
      healthy_q <= healthy_now;
      bonus_q   <= all_max;
      score_q   <= score_d;
      tcnt_q    <= tcnt_d;
      tick_q    <= tick_now;
      cleared_q <= fire;
      if (score_q > best_q) begin
        best_q     <= score_q;
        new_best_q <= 1'b1;
      end else begin
        new_best_q <= 1'b0;
      end
    end
  end

  assign score      = score_q;
  assign best_score = best_q;
  assign tick       = tick_q;
  assign cleared    = cleared_q;
  assign new_best   = new_best_q;

`ifdef SCORE_BCD_EN
  logic bcd_busy, bcd_done, bcd_valid_q, bcd_start;

  assign bcd_start = (score_d != score_q);

  score_bin2bcd #(.BIN_W(SCORE_W), .DIGITS(4)) u_bcd (
    .clk     (clk),
    .rst_n   (rst_n),
    .start_i (bcd_start),
    .bin_i   (score_d),
    .busy_o  (bcd_busy),
    .done_o  (bcd_done),
    .bcd_o   (score_bcd)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)          bcd_valid_q <= 1'b1;
    else if (bcd_start)  bcd_valid_q <= 1'b0;
    else if (bcd_done)   bcd_valid_q <= 1'b1;
  end

  assign bcd_valid = bcd_valid_q & ~bcd_busy;
`endif

endmodule

// File: tb/tb_score_tracker.sv
// Directed bench for score_tracker with TICK_CYCLES=10, HOLD_CYCLES=20.
module tb_score_tracker;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [14:0] stats;
  logic        pause;
  logic        clear_btn;
  logic [13:0] score, best_score;
  logic        tick, cleared, new_best;

  int n_checks = 0;
  int n_err    = 0;

  always #5 clk = ~clk;

  score_tracker #(.TICK_CYCLES(10), .HOLD_CYCLES(20)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .stats      (stats),
    .pause      (pause),
    .clear_btn  (clear_btn),
    .score      (score),
    .best_score (best_score),
    .tick       (tick),
    .cleared    (cleared),
    .new_best   (new_best)
  );

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic set_stats(input logic [2:0] s0, input logic [2:0] s1, input logic [2:0] s2,
                           input logic [2:0] s3, input logic [2:0] s4);
    stats = {s4, s3, s2, s1, s0};
  endtask

  // Steps until a tick pulse is seen; afterwards the internal counter is 0.
  task automatic wait_tick(input string tag);
    int n;
    n = 0;
    do begin
      step(1);
      n++;
    end while (tick !== 1'b1 && n < 30);
    check(tag, 32'(tick), 32'd1);
  endtask

  initial begin
    int pulses;
    pause = 1'b0;
    clear_btn = 1'b0;
    set_stats(7, 7, 7, 7, 7);

    // 1: reset with everything at max must not score
    #12;
    check("rst_score", 32'(score), 0);
    check("rst_best", 32'(best_score), 0);
    check("rst_tick", 32'(tick), 0);
    check("rst_cleared", 32'(cleared), 0);
    check("rst_new_best", 32'(new_best), 0);
    @(posedge clk);
    #1 rst_n = 1'b1;
    step(30);
    check("armed_off_score", 32'(score), 0);
    check("armed_off_best", 32'(best_score), 0);

    // 2: single rising stat, then re-arm and rise again
    set_stats(5, 5, 5, 5, 5);
    step(2);
    set_stats(6, 5, 5, 5, 5);
    step(1);
    check("rise1_score", 32'(score), 1);
    step(1);
    check("rise1_best", 32'(best_score), 1);
    check("rise1_new_best", 32'(new_best), 1);
    step(1);
    check("rise1_new_best_drop", 32'(new_best), 0);
    check("rise1_hold", 32'(score), 1);
    set_stats(5, 5, 5, 5, 5);
    step(1);
    set_stats(6, 5, 5, 5, 5);
    step(1);
    check("rise2_score", 32'(score), 2);

    // 3: bonus entry on the tick cycle, zero loss merged
    set_stats(6, 6, 6, 6, 6);
    step(1);
    check("rise4_score", 32'(score), 6);
    wait_tick("s3_sync");
    step(9);
    set_stats(7, 7, 7, 7, 7);
    step(1);
    check("bonus_tick", 32'(tick), 1);
    check("bonus_score", 32'(score), 11);
    step(1);
    check("bonus_best", 32'(best_score), 11);

    // 5: long-press clear fires once
    clear_btn = 1'b1;
    step(19);
    check("clr_early", 32'(cleared), 0);
    check("clr_early_score", 32'(score), 11);
    step(1);
    check("clr_pulse", 32'(cleared), 1);
    check("clr_score", 32'(score), 0);
    step(1);
    check("clr_pulse_end", 32'(cleared), 0);
    pulses = 0;
    for (int i = 0; i < 50; i++) begin
      step(1);
      if (cleared === 1'b1) pulses++;
    end
    check("clr_no_refire", 32'(pulses), 0);
    check("clr_best_kept", 32'(best_score), 11);
    check("clr_held_score", 32'(score), 0);
    clear_btn = 1'b0;
    step(1);

    // 4: floor on heavy decay
    set_stats(5, 5, 5, 7, 7);
    step(1);
    set_stats(6, 6, 6, 7, 7);
    step(1);
    check("floor_pre", 32'(score), 3);
    wait_tick("s4_sync");
    step(9);
    set_stats(0, 0, 1, 4, 4);
    step(1);
    check("floor_tick", 32'(tick), 1);
    check("floor_score", 32'(score), 0);
    set_stats(5, 5, 5, 5, 5);
    step(1);
    check("floor_rest", 32'(score), 0);

    // 4: climb to the ceiling (each 5->7 round adds 5 rises + 5 bonus)
    for (int i = 0; i < 998; i++) begin
      set_stats(7, 7, 7, 7, 7);
      step(1);
      set_stats(5, 5, 5, 5, 5);
      step(1);
    end
    check("climb_9980", 32'(score), 9980);
    set_stats(7, 7, 7, 7, 7);
    step(1);
    check("climb_9990", 32'(score), 9990);
    set_stats(7, 7, 7, 5, 5);
    step(1);
    set_stats(7, 7, 7, 7, 7);
    step(1);
    check("climb_9997", 32'(score), 9997);
    set_stats(7, 7, 7, 5, 5);
    step(1);
    set_stats(7, 7, 7, 7, 7);
    step(1);
    check("ceiling", 32'(score), 9999);
    step(1);
    check("ceiling_best", 32'(best_score), 9999);
    check("ceiling_new_best", 32'(new_best), 1);

    // 6: pause freezes the tick counter mid-count
    wait_tick("s6_sync");
    step(4);
    pause = 1'b1;
    set_stats(1, 1, 1, 7, 7);
    pulses = 0;
    for (int i = 0; i < 25; i++) begin
      step(1);
      if (tick === 1'b1) pulses++;
    end
    check("pause_no_tick", 32'(pulses), 0);
    check("pause_score", 32'(score), 9999);
    pause = 1'b0;
    step(5);
    check("resume_no_tick_yet", 32'(tick), 0);
    check("resume_score_hold", 32'(score), 9999);
    step(1);
    check("resume_tick", 32'(tick), 1);
    check("resume_loss", 32'(score), 9996);

    // async reset mid-hold discards the partial hold count
    clear_btn = 1'b1;
    step(5);
    rst_n = 1'b0;
    #1;
    check("async_rst_score", 32'(score), 0);
    check("async_rst_best", 32'(best_score), 0);
    @(posedge clk);
    #1 rst_n = 1'b1;
    step(19);
    check("rehold_early", 32'(cleared), 0);
    step(1);
    check("rehold_pulse", 32'(cleared), 1);

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

endmodule
